// File: rtl/mmio_pkg.sv
// Shared register map and bit positions for the MMIO timer/TX peripheral.
// The software header generator reads the same constants.
package mmio_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 3;

    // Byte offsets of the registers
    localparam int unsigned OFF_CTRL   = 'h00;
    localparam int unsigned OFF_COUNT  = 'h04;
    localparam int unsigned OFF_CMP    = 'h08;
    localparam int unsigned OFF_STATUS = 'h0C;
    localparam int unsigned OFF_TXDATA = 'h10;
    localparam int unsigned OFF_PRESC  = 'h14;

    // CTRL bit indices
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_IRQ_EN      = 1;
    localparam int unsigned CTRL_AUTO_RELOAD = 2;

    // STATUS bit indices
    localparam int unsigned ST_MATCH     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_LEVEL_LSB = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // CTRL register layout, MSB first so bit 0 is en
    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Word index of a byte offset, as decoded from m_addr[4:2]
    function automatic reg_idx_t reg_idx(input int unsigned off);
        return reg_idx_t'(off >> 2);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; push while full is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // Head is forced to zero while empty so stale storage never leaks out
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed, reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Zero-wait-state MMIO peripheral: prescaled 32-bit timer with compare
// match/interrupt and a byte TX FIFO drained by an external consumer.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PRESC_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_sel,
    input  logic              m_rnw,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_data,
    output logic [31:0]       s_data,
    output logic              irq,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    ctrl_t               ctrl;
    logic [DATA_W-1:0]   count;
    logic [DATA_W-1:0]   cmp;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_cnt;
    logic                match;
    logic                ovf;

    reg_idx_t            idx;
    logic                wr;
    logic                wr_ctrl;
    logic                wr_count;
    logic                wr_cmp;
    logic                wr_status;
    logic                wr_txdata;
    logic                wr_presc;

    logic                tick;
    logic                at_cmp;
    logic                set_match;
    logic                set_ovf;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;
    logic [DATA_W-1:0]   status_word;
    logic [DATA_W-1:0]   rdata;
    logic                unused_addr;

    // Only word index bits are decoded; the rest is accepted and ignored
    assign unused_addr = ^{m_addr[31:5], m_addr[1:0]};

    assign idx       = m_addr[4:2];
    assign wr        = m_sel & ~m_rnw;
    assign wr_ctrl   = wr && (idx == reg_idx(OFF_CTRL));
    assign wr_count  = wr && (idx == reg_idx(OFF_COUNT));
    assign wr_cmp    = wr && (idx == reg_idx(OFF_CMP));
    assign wr_status = wr && (idx == reg_idx(OFF_STATUS));
    assign wr_txdata = wr && (idx == reg_idx(OFF_TXDATA));
    assign wr_presc  = wr && (idx == reg_idx(OFF_PRESC));

    // >= rather than == so a PRESC lowered below the running count still ticks
    assign tick      = ctrl.en && (presc_cnt >= presc);
    assign at_cmp    = (count == cmp);
    assign set_match = tick & at_cmp;

    assign tx_valid  = ~fifo_empty;
    assign fifo_pop  = tx_valid & tx_ready;
    // A push into a full FIFO is only lost when no pop frees a slot
    assign set_ovf   = wr_txdata & fifo_full & ~fifo_pop;

    // Both terms are flops, so irq follows match with no added cycle
    assign irq       = match & ctrl.irq_en;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (m_data[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Plain read/write configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= '0;
            cmp   <= '0;
            presc <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(m_data[2:0]);
            end
            if (wr_cmp) begin
                cmp <= m_data;
            end
            if (wr_presc) begin
                presc <= m_data[PRESC_W-1:0];
            end
        end
    end

    // Prescaler and counter; a COUNT write overrides a same-cycle tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            count     <= '0;
        end else begin
            if (wr_count) begin
                presc_cnt <= '0;
                count     <= m_data;
            end else begin
                if (tick) begin
                    presc_cnt <= '0;
                end else if (ctrl.en) begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
                if (tick) begin
                    // Auto-reload restarts the count when it reaches CMP
                    if (at_cmp && ctrl.auto_reload) begin
                        count <= '0;
                    end else begin
                        count <= count + DATA_W'(1);
                    end
                end
            end
        end
    end

    // Sticky status flags; a new event beats a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            match <= set_match | (match & ~(wr_status & m_data[ST_MATCH]));
            ovf   <= set_ovf   | (ovf   & ~(wr_status & m_data[ST_OVF]));
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word                            = '0;
        status_word[ST_MATCH]                  = match;
        status_word[ST_FULL]                   = fifo_full;
        status_word[ST_EMPTY]                  = fifo_empty;
        status_word[ST_OVF]                    = ovf;
        status_word[ST_LEVEL_LSB +: LVL_W]     = fifo_level;
    end

    // Side-effect-free read mux; TXDATA and unmapped slots read zero
    always_comb begin
        rdata = '0;
        case (idx)
            reg_idx(OFF_CTRL):   rdata = DATA_W'(ctrl);
            reg_idx(OFF_COUNT):  rdata = count;
            reg_idx(OFF_CMP):    rdata = cmp;
            reg_idx(OFF_STATUS): rdata = status_word;
            reg_idx(OFF_PRESC):  rdata = DATA_W'(presc);
            default:             rdata = '0;
        endcase
        s_data = (m_sel & m_rnw) ? rdata : '0;
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: timer, auto-reload, FIFO with a
// byte scoreboard, simultaneous events, spurious reads and async reset.
module tb_mmio_responder;

    localparam logic [2:0] I_CTRL   = 3'd0;
    localparam logic [2:0] I_COUNT  = 3'd1;
    localparam logic [2:0] I_CMP    = 3'd2;
    localparam logic [2:0] I_STATUS = 3'd3;
    localparam logic [2:0] I_TXDATA = 3'd4;
    localparam logic [2:0] I_PRESC  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_sel;
    logic        m_rnw;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] s_data;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sb_q[$];

    mmio_responder #(
        .FIFO_DEPTH (8),
        .PRESC_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_sel    (m_sel),
        .m_rnw    (m_rnw),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .s_data   (s_data),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        m_sel  = 1'b1;
        m_rnw  = 1'b0;
        m_addr = {27'h0, idx, 2'b00};
        m_data = d;
        @(posedge clk);
        #1;
        m_sel  = 1'b0;
        m_rnw  = 1'b1;
        m_data = '0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d);
        m_sel  = 1'b1;
        m_rnw  = 1'b1;
        m_addr = {27'h0, idx, 2'b00};
        #1;
        d      = s_data;
        m_sel  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        rd(idx, d);
        chk(tag, d, exp);
    endtask

    // Push through the bus; the scoreboard keeps only bytes the FIFO can hold
    task automatic push_byte(input logic [7:0] b);
        if (sb_q.size() < 8) sb_q.push_back(b);
        wr(I_TXDATA, {24'hABCDEF, b});
    endtask

    initial begin
        logic [31:0] exp_map [8];
        int          m_count;
        logic        m_match;
        logic        clr;
        logic        wrap;
        logic [7:0]  head;
        int          guard;
        logic [2:0]  ridx;

        rst_n    = 1'b0;
        m_sel    = 1'b0;
        m_rnw    = 1'b1;
        m_addr   = '0;
        m_data   = '0;
        tx_ready = 1'b0;
        cyc(3);
        chk("rst_s_data", s_data, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        rst_n = 1'b1;
        cyc(1);
        rd_chk("rst_ctrl", I_CTRL, 32'h0);
        rd_chk("rst_count", I_COUNT, 32'h0);
        rd_chk("rst_status", I_STATUS, 32'h4);

        // Timer match with PRESC=1: one tick every 2 cycles
        wr(I_PRESC, 32'h1);
        wr(I_CMP, 32'h5);
        wr(I_COUNT, 32'h0);
        wr(I_CTRL, 32'h3);
        cyc(10);
        rd_chk("tmr_count5", I_COUNT, 32'h5);
        chk("tmr_irq_low", {31'h0, irq}, 32'h0);
        cyc(2);
        rd_chk("tmr_count6", I_COUNT, 32'h6);
        chk("tmr_irq_high", {31'h0, irq}, 32'h1);
        rd_chk("tmr_status", I_STATUS, 32'h5);
        wr(I_STATUS, 32'h1);
        chk("tmr_irq_cleared", {31'h0, irq}, 32'h0);
        wr(I_CTRL, 32'h0);
        cyc(5);
        rd_chk("tmr_frozen", I_COUNT, 32'h7);

        // Auto-reload, PRESC=0: tick every cycle, wrap at CMP=3
        wr(I_COUNT, 32'h0);
        wr(I_CMP, 32'h3);
        wr(I_PRESC, 32'h0);
        wr(I_CTRL, 32'h7);
        m_count = 0;
        m_match = 1'b0;
        for (int i = 0; i < 12; i++) begin
            clr = (i == 3) || (i == 5);
            if (clr) wr(I_STATUS, 32'h1);
            else     cyc(1);
            wrap    = (m_count == 3);
            m_count = wrap ? 0 : m_count + 1;
            m_match = wrap | (m_match & ~clr);
            begin
                logic [31:0] d;
                rd(I_COUNT, d);
                chk("ar_count", d, 32'(m_count));
                rd(I_STATUS, d);
                chk("ar_match", {31'h0, d[0]}, {31'h0, m_match});
                chk("ar_irq", {31'h0, irq}, {31'h0, m_match});
            end
        end

        // COUNT write on a tick cycle wins over the increment
        wr(I_COUNT, 32'h100);
        rd_chk("cw_tick", I_COUNT, 32'h100);
        cyc(1);
        rd_chk("cw_next", I_COUNT, 32'h101);
        wr(I_CTRL, 32'h0);
        wr(I_STATUS, 32'h1);
        rd_chk("cw_frozen", I_COUNT, 32'h102);

        // FIFO fill, overflow, simultaneous push/pop, drain
        for (int i = 0; i < 8; i++) push_byte(8'(8'h41 + i));
        rd_chk("fifo_full", I_STATUS, 32'h82);
        chk("fifo_head", {24'h0, tx_data}, 32'h41);
        chk("fifo_valid", {31'h0, tx_valid}, 32'h1);
        push_byte(8'h49);
        rd_chk("fifo_ovf", I_STATUS, 32'h8A);
        chk("fifo_head_ovf", {24'h0, tx_data}, 32'h41);
        wr(I_STATUS, 32'h8);
        rd_chk("fifo_ovf_clr", I_STATUS, 32'h82);

        tx_ready = 1'b1;
        head = sb_q.pop_front();
        chk("sim_head", {24'h0, tx_data}, {24'h0, head});
        sb_q.push_back(8'h4A);
        wr(I_TXDATA, 32'h4A);
        tx_ready = 1'b0;
        rd_chk("sim_push_pop", I_STATUS, 32'h82);

        guard    = 0;
        tx_ready = 1'b1;
        while (tx_valid && guard < 20) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", {24'h0, tx_data}, 32'h0);
            end else begin
                head = sb_q.pop_front();
                chk("tx_order", {24'h0, tx_data}, {24'h0, head});
            end
            cyc(1);
            guard++;
        end
        tx_ready = 1'b0;
        chk("drain_cnt", 32'(guard), 32'h8);
        chk("drain_left", 32'(sb_q.size()), 32'h0);
        rd_chk("fifo_empty", I_STATUS, 32'h4);
        chk("empty_tx_data", {24'h0, tx_data}, 32'h0);

        // Spurious reads on every offset change nothing
        wr(I_COUNT, 32'h1234);
        wr(I_CMP, 32'hA5A5);
        wr(I_PRESC, 32'h7);
        push_byte(8'h11);
        push_byte(8'h22);
        exp_map[0] = 32'h0;
        exp_map[1] = 32'h1234;
        exp_map[2] = 32'hA5A5;
        exp_map[3] = 32'h20;
        exp_map[4] = 32'h0;
        exp_map[5] = 32'h7;
        exp_map[6] = 32'h0;
        exp_map[7] = 32'h0;
        for (int i = 0; i < 20; i++) begin
            ridx   = 3'(i);
            m_sel  = 1'b1;
            m_rnw  = 1'b1;
            m_data = 32'hFFFF_FFFF;
            m_addr = {27'(i * 37), ridx, 2'(i)};
            #1;
            chk("spur_read", s_data, exp_map[ridx]);
            @(posedge clk);
            #1;
        end
        m_sel  = 1'b0;
        m_data = '0;
        rd_chk("spur_status", I_STATUS, 32'h20);
        rd_chk("spur_count", I_COUNT, 32'h1234);
        chk("spur_head", {24'h0, tx_data}, 32'h11);

        // Async reset in the middle of operation
        wr(I_CMP, 32'h1234);
        wr(I_CTRL, 32'h3);
        cyc(10);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        push_byte(8'h33);
        rd_chk("pre_rst_status", I_STATUS, 32'h31);
        rd_chk("pre_rst_count", I_COUNT, 32'h1235);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("arst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        chk("arst_s_data", s_data, 32'h0);
        rd_chk("arst_ctrl", I_CTRL, 32'h0);
        rd_chk("arst_count", I_COUNT, 32'h0);
        rd_chk("arst_cmp", I_CMP, 32'h0);
        rd_chk("arst_status", I_STATUS, 32'h4);
        rd_chk("arst_presc", I_PRESC, 32'h0);
        sb_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);
        rd_chk("post_rst_count", I_COUNT, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
